// File: rtl/cpu_defs.sv
// Shared CPU encodings for the Memory1 data-cache request port and the SRAM-like bus.
package cpu_defs;

  localparam logic [2:0] DC_NOP = 3'd0;
  localparam logic [2:0] DC_R   = 3'd1;
  localparam logic [2:0] DC_W   = 3'd2;

  typedef enum logic [1:0] {
    BYTE      = 2'd0,
    HALF_WORD = 2'd1,
    WORD      = 2'd2
  } byte_type_t;

  typedef enum logic [1:0] {
    BUS_SIZE_BYTE = 2'd0,
    BUS_SIZE_HALF = 2'd1,
    BUS_SIZE_WORD = 2'd2
  } bus_size_t;

  typedef enum logic [1:0] {
    UC_IDLE = 2'd0,
    UC_ADDR = 2'd1,
    UC_DATA = 2'd2,
    UC_DONE = 2'd3
  } uc_state_t;

  function automatic logic [2:0] op_class(input logic [4:0] op);
    return op[4:2];
  endfunction

  // Bus size encoding deliberately equals byte_type, so this is a pure retype.
  function automatic bus_size_t to_bus_size(input logic [1:0] bt);
    return bus_size_t'(bt);
  endfunction

endpackage

// File: rtl/dcache_uncached_responder_strb_gen.sv
// Byte-strobe and read-alignment shift derived from access size and low address bits.
module uc_strb_gen
  import cpu_defs::*;
(
  input  logic [1:0] byte_type,
  input  logic [1:0] addr_lo,
  input  logic       is_write,
  output logic [3:0] wstrb,
  output logic [4:0] rshift
);

  always_comb begin
    wstrb = 4'b0000;
    if (is_write) begin
      case (byte_type_t'(byte_type))
        BYTE:      wstrb = 4'b0001 << addr_lo;
        HALF_WORD: wstrb = 4'b0011 << {addr_lo[1], 1'b0};
        default:   wstrb = 4'b1111;
      endcase
    end
  end

  assign rshift = {addr_lo, 3'b000};

endmodule

// File: rtl/dcache_uncached_responder.sv
// Uncached single-beat responder for the Memory1 data-cache port; one transaction
// in flight, Memory1 held stalled until dcache_ready.
module dcache_uncached_responder
  import cpu_defs::*;
#(
  parameter bit ALIGN_RDATA = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  dcache_op,
  input  logic [31:0] dcache_pa,
  input  logic        dcache_is_cached,
  input  logic [31:0] wr_dcache_data,
  input  logic        flush,
  output logic        dcache_ready,
  output logic [31:0] rd_data,
  output logic        rd_valid,
  output logic        bus_req,
  output logic        bus_wr,
  output logic [1:0]  bus_size,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_wstrb,
  output logic [31:0] bus_wdata,
  input  logic        bus_addr_ok,
  input  logic        bus_data_ok,
  input  logic [31:0] bus_rdata
);

  typedef struct packed {
    logic [4:0]  op;
    logic [31:0] pa;
    logic [31:0] wdata;
  } uc_req_t;

  uc_state_t   state_q, state_d;
  uc_req_t     req_q, req_d;
  logic        abandoned_q, abandoned_d;
  logic [31:0] rd_data_q, rd_data_d;

  logic        req_is_read;
  logic        req_is_write;
  logic        data_done;
  logic [3:0]  wstrb;
  logic [4:0]  rshift;
  logic [31:0] rdata_aligned;
  logic [2:0]  in_class;
  logic        unused_inputs;

  // Every access goes out uncached, so the MAT bit has no effect.
  assign unused_inputs = dcache_is_cached;

  assign in_class     = op_class(dcache_op);
  assign req_is_read  = (op_class(req_q.op) == DC_R);
  assign req_is_write = (op_class(req_q.op) == DC_W);

  uc_strb_gen u_strb_gen (
    .byte_type (req_q.op[1:0]),
    .addr_lo   (req_q.pa[1:0]),
    .is_write  (req_is_write),
    .wstrb     (wstrb),
    .rshift    (rshift)
  );

  assign rdata_aligned = ALIGN_RDATA ? (bus_rdata >> rshift) : bus_rdata;
  assign rd_data       = rd_data_q;

  always_comb begin
    state_d      = state_q;
    req_d        = req_q;
    abandoned_d  = abandoned_q;
    rd_data_d    = rd_data_q;
    data_done    = 1'b0;
    dcache_ready = 1'b0;
    rd_valid     = 1'b0;
    bus_req      = 1'b0;
    bus_wr       = 1'b0;
    bus_size     = 2'b00;
    bus_addr     = 32'h0;
    bus_wstrb    = 4'b0000;
    bus_wdata    = 32'h0;

    case (state_q)
      UC_IDLE: begin
        if ((in_class == DC_R || in_class == DC_W) && !flush) begin
          req_d   = '{op: dcache_op, pa: dcache_pa, wdata: wr_dcache_data};
          state_d = UC_ADDR;
        end
      end
      UC_ADDR: begin
        bus_req   = 1'b1;
        bus_wr    = req_is_write;
        bus_size  = to_bus_size(req_q.op[1:0]);
        bus_addr  = req_q.pa;
        bus_wstrb = wstrb;
        bus_wdata = req_q.wdata;
        if (flush) abandoned_d = 1'b1;
        if (bus_addr_ok) begin
          // A data_ok alongside addr_ok completes the whole transfer this cycle.
          if (bus_data_ok) begin
            data_done = 1'b1;
            state_d   = UC_DONE;
          end else begin
            state_d = UC_DATA;
          end
        end
      end
      UC_DATA: begin
        if (flush) abandoned_d = 1'b1;
        if (bus_data_ok) begin
          data_done = 1'b1;
          state_d   = UC_DONE;
        end
      end
      UC_DONE: begin
        // The abandon decision is frozen on entry; the clear below wins over a late flush.
        if (!abandoned_q) begin
          dcache_ready = 1'b1;
          rd_valid     = req_is_read;
        end
        abandoned_d = 1'b0;
        state_d     = UC_IDLE;
      end
      default: state_d = UC_IDLE;
    endcase

    // rd_data is loaded on the edge into DONE so it is valid alongside rd_valid.
    if (data_done && req_is_read && !abandoned_d) rd_data_d = rdata_aligned;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= UC_IDLE;
      req_q       <= '0;
      abandoned_q <= 1'b0;
      rd_data_q   <= 32'h0;
    end else begin
      state_q     <= state_d;
      req_q       <= req_d;
      abandoned_q <= abandoned_d;
      rd_data_q   <= rd_data_d;
    end
  end

endmodule

// File: tb/tb_dcache_uncached_responder.sv
// Directed table-driven bench for dcache_uncached_responder plus flush/reset sequences.
module tb_dcache_uncached_responder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  dcache_op;
  logic [31:0] dcache_pa;
  logic        dcache_is_cached;
  logic [31:0] wr_dcache_data;
  logic        flush;
  logic        dcache_ready;
  logic [31:0] rd_data;
  logic        rd_valid;
  logic        bus_req;
  logic        bus_wr;
  logic [1:0]  bus_size;
  logic [31:0] bus_addr;
  logic [3:0]  bus_wstrb;
  logic [31:0] bus_wdata;
  logic        bus_addr_ok;
  logic        bus_data_ok;
  logic [31:0] bus_rdata;

  always #5 clk = ~clk;

  dcache_uncached_responder #(.ALIGN_RDATA(1'b1)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .dcache_op        (dcache_op),
    .dcache_pa        (dcache_pa),
    .dcache_is_cached (dcache_is_cached),
    .wr_dcache_data   (wr_dcache_data),
    .flush            (flush),
    .dcache_ready     (dcache_ready),
    .rd_data          (rd_data),
    .rd_valid         (rd_valid),
    .bus_req          (bus_req),
    .bus_wr           (bus_wr),
    .bus_size         (bus_size),
    .bus_addr         (bus_addr),
    .bus_wstrb        (bus_wstrb),
    .bus_wdata        (bus_wdata),
    .bus_addr_ok      (bus_addr_ok),
    .bus_data_ok      (bus_data_ok),
    .bus_rdata        (bus_rdata)
  );

  localparam logic [4:0] OP_NOP = 5'b000_00;
  localparam logic [4:0] OP_LB  = 5'b001_00;
  localparam logic [4:0] OP_LH  = 5'b001_01;
  localparam logic [4:0] OP_LW  = 5'b001_10;
  localparam logic [4:0] OP_SB  = 5'b010_00;
  localparam logic [4:0] OP_SH  = 5'b010_01;
  localparam logic [4:0] OP_SW  = 5'b010_10;

  typedef struct {
    logic [4:0]  op;
    logic [31:0] pa;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          addr_at;
    int          data_at;
    int          flush_at;
    logic        exp_wr;
    logic [1:0]  exp_size;
    logic [3:0]  exp_strb;
    logic        exp_ready;
    logic        exp_rv;
    logic [31:0] exp_rd;
  } vec_t;

  int n_checks = 0;
  int n_fail   = 0;
  vec_t vecs[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h required 0x%08h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [4:0] op, input logic [31:0] pa, input logic [31:0] wdata,
                              input logic [31:0] rdata, input int addr_at, input int data_at,
                              input int flush_at, input logic exp_wr, input logic [1:0] exp_size,
                              input logic [3:0] exp_strb, input logic exp_ready, input logic exp_rv,
                              input logic [31:0] exp_rd);
    vec_t v;
    v.op = op; v.pa = pa; v.wdata = wdata; v.rdata = rdata;
    v.addr_at = addr_at; v.data_at = data_at; v.flush_at = flush_at;
    v.exp_wr = exp_wr; v.exp_size = exp_size; v.exp_strb = exp_strb;
    v.exp_ready = exp_ready; v.exp_rv = exp_rv; v.exp_rd = exp_rd;
    return v;
  endfunction

  // Called at a negedge with the DUT idle; cycle index 0 is the first ADDR cycle.
  task automatic run_txn(input vec_t v, input string tag);
    int ready_cnt = 0;
    int rv_cnt    = 0;
    int req_cnt   = 0;
    int ready_cyc = -1;
    logic [31:0] rv_data = 32'h0;
    dcache_op      = v.op;
    dcache_pa      = v.pa;
    wr_dcache_data = v.wdata;
    @(negedge clk);
    dcache_op      = OP_NOP;
    dcache_pa      = 32'hFFFF_FFFF;
    wr_dcache_data = 32'hFFFF_FFFF;
    chk({tag, ".bus_req"},   {31'h0, bus_req},   32'h1);
    chk({tag, ".bus_wr"},    {31'h0, bus_wr},    {31'h0, v.exp_wr});
    chk({tag, ".bus_size"},  {30'h0, bus_size},  {30'h0, v.exp_size});
    chk({tag, ".bus_wstrb"}, {28'h0, bus_wstrb}, {28'h0, v.exp_strb});
    chk({tag, ".bus_addr"},  bus_addr,           v.pa);
    if (v.exp_wr) chk({tag, ".bus_wdata"}, bus_wdata, v.wdata);
    for (int c = 0; c < 12; c++) begin
      if (bus_req) req_cnt++;
      if (dcache_ready) begin ready_cnt++; ready_cyc = c; end
      if (rd_valid) begin rv_cnt++; rv_data = rd_data; end
      bus_addr_ok = (c == v.addr_at);
      bus_data_ok = (c == v.data_at);
      bus_rdata   = (c == v.data_at) ? v.rdata : 32'h0BAD_0BAD;
      flush       = (c == v.flush_at);
      @(negedge clk);
    end
    bus_addr_ok = 1'b0;
    bus_data_ok = 1'b0;
    bus_rdata   = 32'h0;
    flush       = 1'b0;
    chk({tag, ".req_cycles"}, req_cnt,   v.addr_at + 1);
    chk({tag, ".ready_cnt"},  ready_cnt, {31'h0, v.exp_ready});
    if (v.exp_ready) chk({tag, ".ready_cycle"}, ready_cyc, v.data_at + 1);
    chk({tag, ".rd_valid_cnt"}, rv_cnt, {31'h0, v.exp_rv});
    if (v.exp_rv) chk({tag, ".rd_data_at_valid"}, rv_data, v.exp_rd);
    chk({tag, ".rd_data_after"}, rd_data, v.exp_rd);
    $display("txn %s op=%05b pa=0x%08h ready=%0d rd_valid=%0d rd_data=0x%08h",
             tag, v.op, v.pa, ready_cnt, rv_cnt, rd_data);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t fv;
    rst_n = 1'b0;
    dcache_op = OP_NOP; dcache_pa = 32'h0; wr_dcache_data = 32'h0;
    dcache_is_cached = 1'b0; flush = 1'b0;
    bus_addr_ok = 1'b0; bus_data_ok = 1'b0; bus_rdata = 32'h0;

    //          op     pa            wdata         rdata        a  d  f   wr  sz     strb     rdy  rv  rd_after
    vecs[0] = mk(OP_LW, 32'h1C00_0010, 32'h0,        32'hDEAD_BEEF, 0, 2, -1, 0, 2'd2, 4'b0000, 1, 1, 32'hDEAD_BEEF);
    vecs[1] = mk(OP_LB, 32'h1C00_0013, 32'h0,        32'hAB00_0000, 0, 1, -1, 0, 2'd0, 4'b0000, 1, 1, 32'h0000_00AB);
    vecs[2] = mk(OP_SH, 32'h1C00_0006, 32'h1234_0000, 32'h0,        1, 2, -1, 1, 2'd1, 4'b1100, 1, 0, 32'h0000_00AB);
    vecs[3] = mk(OP_LW, 32'h1C00_0020, 32'h0,        32'h1122_3344, 0, 0, -1, 0, 2'd2, 4'b0000, 1, 1, 32'h1122_3344);
    vecs[4] = mk(OP_SB, 32'h1C00_0001, 32'h0000_CD00, 32'h0,        2, 2, -1, 1, 2'd0, 4'b0010, 1, 0, 32'h1122_3344);
    vecs[5] = mk(OP_LH, 32'h1C00_0002, 32'h0,        32'h5678_ABCD, 0, 0, -1, 0, 2'd1, 4'b0000, 1, 1, 32'h0000_5678);
    vecs[6] = mk(OP_SW, 32'h1C00_0008, 32'hCAFE_F00D, 32'h0,        0, 3, -1, 1, 2'd2, 4'b1111, 1, 0, 32'h0000_5678);

    #12;
    chk("reset.ready",    {31'h0, dcache_ready}, 32'h0);
    chk("reset.rd_valid", {31'h0, rd_valid},     32'h0);
    chk("reset.rd_data",  rd_data,               32'h0);
    chk("reset.bus_req",  {31'h0, bus_req},      32'h0);
    chk("reset.bus_addr", bus_addr,              32'h0);
    chk("reset.bus_wstrb", {28'h0, bus_wstrb},   32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 7; i++) begin
      dcache_is_cached = i[0];
      run_txn(vecs[i], $sformatf("vec%0d", i));
    end

    // Load abandoned by a flush in DATA; the bus still finishes three cycles later.
    fv = mk(OP_LW, 32'h1C00_0030, 32'h0, 32'h9999_9999, 0, 4, 1, 0, 2'd2, 4'b0000, 0, 0, 32'h0000_5678);
    run_txn(fv, "flush_in_data");
    fv = mk(OP_LB, 32'h1C00_0031, 32'h0, 32'h0000_EE00, 0, 0, -1, 0, 2'd0, 4'b0000, 1, 1, 32'h0000_00EE);
    run_txn(fv, "after_flush");

    // A request presented together with flush in IDLE must not be accepted.
    dcache_op = OP_LW; dcache_pa = 32'h1C00_0050; flush = 1'b1;
    @(negedge clk);
    chk("idle_flush.bus_req", {31'h0, bus_req}, 32'h0);
    dcache_op = OP_NOP; flush = 1'b0;
    @(negedge clk);
    chk("idle_flush.still_idle", {31'h0, bus_req}, 32'h0);
    $display("txn idle_flush bus_req=%0d", bus_req);

    // Asynchronous reset while the load waits in DATA.
    dcache_op = OP_LW; dcache_pa = 32'h1C00_0040;
    @(negedge clk);
    dcache_op = OP_NOP;
    bus_addr_ok = 1'b1;
    @(negedge clk);
    bus_addr_ok = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid.ready",    {31'h0, dcache_ready}, 32'h0);
    chk("rst_mid.rd_valid", {31'h0, rd_valid},     32'h0);
    chk("rst_mid.rd_data",  rd_data,               32'h0);
    chk("rst_mid.bus_req",  {31'h0, bus_req},      32'h0);
    $display("txn reset_in_data rd_data=0x%08h bus_req=%0d", rd_data, bus_req);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    fv = mk(OP_SB, 32'h1C00_0003, 32'h7700_0000, 32'h0, 0, 1, -1, 1, 2'd0, 4'b1000, 1, 0, 32'h0);
    run_txn(fv, "after_reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
